// File: rtl/obj_line_buffer.sv
// rtl/obj_line_buffer.sv - double-banked object line buffer with first-opaque-wins writes and clear-on-read display
// The render bank is BANK_SEL and the display bank is ~BANK_SEL; occupancy bits mask stale data RAM contents.
module obj_line_buffer (
  input  logic       CLK_32M,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic [8:0] HE,
  input  logic       NL,
  input  logic       paused,
  input  logic       WR_VALID,
  input  logic [8:0] WR_X,
  input  logic [8:0] WR_DATA,
  input  logic       P1L,
  output logic [3:0] OBJ_BIT,
  output logic [3:0] OBJ_COL,
  output logic       OBJ_PRI,
  output logic       SEL_OBJ,
  output logic       WR_STORED
);

  logic             r_bank_sel;
  logic [1:0][511:0] r_occ;
  logic [8:0]       r_ram [2][512];
  logic [8:0]       r_obj;
  logic             r_wr_stored;

  logic             w_disp_bank;
  logic             w_wr_en;
  logic             w_clr_en;
  logic             w_swap;
  logic [8:0]       w_rd_data;

  assign w_disp_bank = ~r_bank_sel;
  // Only the first opaque pixel at a given X in a line is kept.
  assign w_wr_en     = WR_VALID && (WR_DATA[3:0] != 4'd0) && !r_occ[r_bank_sel][WR_X];
  assign w_clr_en    = CE_PIX && !paused;
  assign w_swap      = NL && !paused;
  assign w_rd_data   = r_occ[w_disp_bank][HE] ? r_ram[w_disp_bank][HE] : 9'h000;

  always_ff @(posedge CLK_32M) begin
    if (w_wr_en) begin
      r_ram[r_bank_sel][WR_X] <= WR_DATA;
    end
  end

  // Writes and clears never collide: they always address opposite banks.
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      r_bank_sel  <= 1'b0;
      r_occ       <= '0;
      r_obj       <= 9'h000;
      r_wr_stored <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_occ[r_bank_sel][WR_X] <= 1'b1;
      end
      if (w_clr_en) begin
        r_occ[w_disp_bank][HE] <= 1'b0;
      end
      if (CE_PIX) begin
        r_obj <= w_rd_data;
      end
      r_wr_stored <= w_wr_en;
      if (w_swap) begin
        r_bank_sel <= ~r_bank_sel;
      end
    end
  end

  assign OBJ_PRI   = r_obj[8];
  assign OBJ_COL   = r_obj[7:4];
  assign OBJ_BIT   = r_obj[3:0];
  assign WR_STORED = r_wr_stored;
  assign SEL_OBJ   = (r_obj[3:0] != 4'd0) & (r_obj[8] | P1L);

endmodule

// File: tb/tb_obj_line_buffer.sv
// tb/tb_obj_line_buffer.sv - randomized and directed bench for obj_line_buffer against an array-based line model
module tb_obj_line_buffer;

  logic       clk;
  logic       rst;
  logic       ce_pix;
  logic [8:0] he;
  logic       nl;
  logic       paused;
  logic       wr_valid;
  logic [8:0] wr_x;
  logic [8:0] wr_data;
  logic       p1l;
  logic [3:0] obj_bit;
  logic [3:0] obj_col;
  logic       obj_pri;
  logic       sel_obj;
  logic       wr_stored;

  int checks;
  int failures;

  bit         m_occ  [2][512];
  logic [8:0] m_data [2][512];
  int         m_bank;
  logic [8:0] m_out;
  logic       m_stored;
  logic [8:0] sweep_ref [512];

  obj_line_buffer dut (
    .CLK_32M   (clk),
    .RESET     (rst),
    .CE_PIX    (ce_pix),
    .HE        (he),
    .NL        (nl),
    .paused    (paused),
    .WR_VALID  (wr_valid),
    .WR_X      (wr_x),
    .WR_DATA   (wr_data),
    .P1L       (p1l),
    .OBJ_BIT   (obj_bit),
    .OBJ_COL   (obj_col),
    .OBJ_PRI   (obj_pri),
    .SEL_OBJ   (sel_obj),
    .WR_STORED (wr_stored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) m_occ[b][a] = 1'b0;
    m_bank   = 0;
    m_out    = 9'h000;
    m_stored = 1'b0;
  endtask

  task automatic idle();
    ce_pix   = 1'b0;
    nl       = 1'b0;
    wr_valid = 1'b0;
    wr_x     = 9'd0;
    wr_data  = 9'd0;
    he       = 9'd0;
  endtask

  // Called at a falling edge with inputs already set; checks after the next falling edge.
  task automatic tick();
    logic st;
    int   d;
    st = wr_valid && (wr_data[3:0] != 4'd0) && !m_occ[m_bank][wr_x];
    if (st) begin
      m_occ[m_bank][wr_x]  = 1'b1;
      m_data[m_bank][wr_x] = wr_data;
    end
    d = 1 - m_bank;
    if (ce_pix) begin
      m_out = m_occ[d][he] ? m_data[d][he] : 9'h000;
      if (!paused) m_occ[d][he] = 1'b0;
    end
    if (nl && !paused) m_bank = 1 - m_bank;
    m_stored = st;
    @(posedge clk);
    @(negedge clk);
    check("obj", {7'd0, obj_pri, obj_col, obj_bit}, {7'd0, m_out});
    check("wr_stored", {15'd0, wr_stored}, {15'd0, m_stored});
    check("sel_obj", {15'd0, sel_obj}, {15'd0, (m_out[3:0] != 4'd0) && (m_out[8] || p1l)});
  endtask

  task automatic wr(input logic [8:0] x, input logic [8:0] d);
    wr_valid = 1'b1; wr_x = x; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [8:0] h);
    ce_pix = 1'b1; he = h;
    tick();
    ce_pix = 1'b0;
  endtask

  task automatic newline();
    nl = 1'b1;
    tick();
    nl = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    paused   = 1'b0;
    p1l      = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_obj", {7'd0, obj_pri, obj_col, obj_bit}, 16'd0);
    check("reset_wr_stored", {15'd0, wr_stored}, 16'd0);
    check("reset_sel", {15'd0, sel_obj}, 16'd0);
    rst = 1'b0;
    tick();

    // basic write, swap and readout
    wr(9'd10, 9'h1A5);
    newline();
    rd(9'd10);
    check("r032_bit", {12'd0, obj_bit}, 16'h5);
    check("r032_col", {12'd0, obj_col}, 16'hA);
    check("r032_pri", {15'd0, obj_pri}, 16'd1);
    check("r032_sel", {15'd0, sel_obj}, 16'd1);
    rd(9'd11);
    check("r032_empty", {7'd0, obj_pri, obj_col, obj_bit}, 16'd0);

    // first opaque pixel wins
    wr(9'd20, 9'h013);
    check("r033_first", {15'd0, wr_stored}, 16'd1);
    wr(9'd20, 9'h027);
    check("r033_second", {15'd0, wr_stored}, 16'd0);
    newline();
    rd(9'd20);
    check("r033_bit", {12'd0, obj_bit}, 16'h3);
    check("r033_col", {12'd0, obj_col}, 16'h1);

    // transparent writes and P1L-gated select
    wr(9'd30, 9'h010);
    check("r034_transp", {15'd0, wr_stored}, 16'd0);
    wr(9'd30, 9'h031);
    newline();
    p1l = 1'b0;
    rd(9'd30);
    check("r034_sel_p1l0", {15'd0, sel_obj}, 16'd0);
    p1l = 1'b1;
    tick();
    check("r034_sel_p1l1", {15'd0, sel_obj}, 16'd1);
    p1l = 1'b0;

    // clear-on-read
    wr(9'd40, 9'h055);
    newline();
    rd(9'd40);
    check("r035_first", {12'd0, obj_bit}, 16'h5);
    newline();
    newline();
    rd(9'd40);
    check("r035_second", {7'd0, obj_pri, obj_col, obj_bit}, 16'd0);

    // paused: no swap, no clear, two identical sweeps
    wr(9'd100, 9'h1C7);
    wr(9'd511, 9'h0F2);
    wr(9'd0, 9'h109);
    newline();
    paused = 1'b1;
    newline();
    for (int i = 0; i < 512; i++) begin
      rd(9'(i));
      sweep_ref[i] = m_out;
    end
    for (int i = 0; i < 512; i++) begin
      rd(9'(i));
      check("r036_sweep", {7'd0, obj_pri, obj_col, obj_bit}, {7'd0, sweep_ref[i]});
    end
    check("r036_px100", {7'd0, sweep_ref[100]}, 16'h1C7);
    paused = 1'b0;

    // asynchronous reset mid-readout
    wr(9'd5, 9'h1F7);
    newline();
    rd(9'd5);
    check("r037_pre", {7'd0, obj_pri, obj_col, obj_bit}, 16'h1F7);
    #2 rst = 1'b1;
    #1;
    check("r037_async_obj", {7'd0, obj_pri, obj_col, obj_bit}, 16'd0);
    check("r037_async_sel", {15'd0, sel_obj}, 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    newline();
    rd(9'd5);
    check("r037_post", {7'd0, obj_pri, obj_col, obj_bit}, 16'd0);

    // randomized traffic on a narrow address window to force collisions
    for (int n = 0; n < 3000; n++) begin
      ce_pix   = 1'($urandom_range(0, 1));
      nl       = !nl && ($urandom_range(0, 29) == 0);
      paused   = ($urandom_range(0, 9) == 0);
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_x     = 9'($urandom_range(0, 31));
      wr_data  = 9'($urandom);
      he       = 9'($urandom_range(0, 31));
      p1l      = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obj_line_buffer.md
OBJ_LINE_BUFFER -- requirements
Module: obj_line_buffer

Interface
REQ-001 CLK_32M  in  1  sole clock; all state updates on its rising edge.
REQ-002 RESET  in  1  reset, asynchronous and active-high.
REQ-003 CE_PIX  in  1  pixel-rate enable; readout/clear advances only on cycles with CE_PIX=1.
REQ-004 HE  in  9  current horizontal pixel position, used as readout address.
REQ-005 NL  in  1  new-line strobe, one CLK_32M cycle wide; swaps banks.
REQ-006 paused  in  1  freeze: suppresses bank swap and readout clear.
REQ-007 WR_VALID  in  1  renderer offers one object pixel this cycle.
REQ-008 WR_X  in  9  target X of offered pixel.
REQ-009 WR_DATA  in  9  {PRI, COL[3:0], BIT[3:0]} of offered pixel.
REQ-010 P1L  in  1  tile-layer "object may show" signal from the tile/palette stage, same pixel timing as the outputs.
REQ-011 OBJ_BIT  out  4  object pixel index; 0 = transparent.
REQ-012 OBJ_COL  out  4  object colour bank.
REQ-013 OBJ_PRI  out  1  object priority bit.
REQ-014 SEL_OBJ  out  1  mixer select: object pixel wins.
REQ-015 WR_STORED  out  1  registered flag: previous-cycle offer was written.

Function
REQ-016 Two banks, each 512 x 9 data RAM plus 512-bit occupancy vector; BANK_SEL register picks render bank (BANK_SEL) and display bank (~BANK_SEL).
REQ-017 NL=1 and paused=0 toggles BANK_SEL at end of that cycle; NL while paused=1 is ignored.
REQ-018 Write offered in same cycle as NL goes to the pre-swap render bank.
REQ-019 Write rule: WR_VALID=1, WR_DATA[3:0]!=0, occupancy[WR_X]=0 in render bank -> store WR_DATA at WR_X, set occupancy bit; otherwise no change (first opaque pixel wins).
REQ-020 WR_STORED = 1 in the cycle after a REQ-019 store, else 0; no backpressure, renderer never stalled.
REQ-021 Readout: on CE_PIX=1, display bank address HE is sampled; if occupancy set, data is loaded into output register, else output register loads 9'h000.
REQ-022 Latency: pixel sampled at CE_PIX enable k appears on OBJ_* after the CLK_32M edge of enable k, stable until enable k+1.
REQ-023 Clear-on-read: same CE_PIX=1 cycle clears display-bank occupancy[HE] unless paused=1.
REQ-024 Render writes and display clears always target different banks; both in one cycle are both performed.
REQ-025 HE wrap 511->0 requires no special handling; each address cleared once per read.
REQ-026 SEL_OBJ = (OBJ_BIT!=0) & (OBJ_PRI | P1L), combinational from registered outputs and P1L.
REQ-027 CE_PIX=0 cycles: outputs hold, no clear performed; writes still accepted.
REQ-028 paused=1: outputs continue to read display bank, writes still honoured per REQ-019.

Reset
REQ-029 RESET=1: BANK_SEL=0, all 1024 occupancy bits 0, OBJ_BIT/OBJ_COL/OBJ_PRI=0, WR_STORED=0, hence SEL_OBJ=0.
REQ-030 RESET mid-line discards all buffered pixels; data RAM contents need not be cleared (occupancy masks them).
REQ-031 RESET release needs no NL before first write; first NL after reset makes bank 0 the display bank.

Verification
REQ-032 Write X=10 data 9'h1A5, NL, CE_PIX with HE=10 -> OBJ_BIT=5, OBJ_COL=A, OBJ_PRI=1, SEL_OBJ=1; HE=11 -> all 0.
REQ-033 Writes X=20 9'h013 then X=20 9'h027 same line -> WR_STORED 1 then 0; readout OBJ_BIT=3, OBJ_COL=1.
REQ-034 Write X=30 9'h010 (BIT=0) -> WR_STORED=0, readout transparent; write 9'h031 then P1L=0 with PRI=0 -> SEL_OBJ=0, P1L=1 -> SEL_OBJ=1.
REQ-035 Read X=40 once after NL, two NLs later read X=40 again without rewrite -> second read all 0 (clear-on-read).
REQ-036 paused=1, NL pulsed, HE swept 0..511 twice -> identical outputs both sweeps, BANK_SEL unchanged.
REQ-037 RESET asserted mid-readout after writes to X=5 -> outputs 0 asynchronously, post-NL read of X=5 returns 0.
